// File: rtl/victim_pkg.sv
// Shared widths and entry type for the victim write-back buffer.
package victim_pkg;

    localparam int ADR_W  = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } victim_entry_t;

endpackage

// File: rtl/victim_wb_buffer_if.sv
// Bus bundle between cache, victim buffer and memory write port.
interface victim_wb_buffer_if;
    import victim_pkg::*;

    logic [ADR_W-1:0]  evicted_adr;
    logic [DATA_W-1:0] evicted_data;
    logic              evicted_valid;
    logic              full;
    logic              overflow;
    logic [ADR_W-1:0]  wr_adr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADR_W-1:0]  lookup_adr;
    logic              lookup_en;
    logic [DATA_W-1:0] lookup_data;
    logic              lookup_hit;

    modport master (
        output evicted_adr, evicted_data, evicted_valid,
        output wr_ready, lookup_adr, lookup_en,
        input  full, overflow, wr_adr, wr_data, wr_valid,
        input  lookup_data, lookup_hit
    );

    modport slave (
        input  evicted_adr, evicted_data, evicted_valid,
        input  wr_ready, lookup_adr, lookup_en,
        output full, overflow, wr_adr, wr_data, wr_valid,
        output lookup_data, lookup_hit
    );

endinterface

// File: rtl/victim_wb_buffer.sv
// Coalescing victim FIFO feeding memory writes; lookup forwarding
// is built only when VICTIM_FWD_EN is defined.
module victim_wb_buffer
    import victim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DEBUG = 0
) (
    input logic          clk,
    input logic          rst,
    victim_wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    victim_entry_t    mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [DEPTH-1:0] qmask, emask;
    logic [PW-1:0]    cidx;
    logic             drain, coal, push, room, do_push;

    // Slot i is live when its distance from head is below count.
    function automatic logic [DEPTH-1:0] live_mask(
        input logic [PW-1:0] head,
        input logic [CW-1:0] cnt
    );
        logic [DEPTH-1:0] m;
        logic [PW-1:0]    off;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off  = PW'(i) - head;
            m[i] = {1'b0, off} < cnt;
        end
        return m;
    endfunction

    assign drain = bus.wr_valid && bus.wr_ready;

    always_comb begin
        qmask = live_mask(head_q, count_q);
        emask = '0;
        cidx  = '0;
        for (int i = 0; i < DEPTH; i++)
            emask[i] = qmask[i] &&
                       (mem_q[i].adr == bus.evicted_adr);
        if (drain)
            emask[head_q] = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (emask[i]) cidx = PW'(i);
    end

    assign coal    = bus.evicted_valid && (|emask);
    assign push    = bus.evicted_valid && !coal;
    assign room    = (count_q != CW'(DEPTH)) || drain;
    assign do_push = push && room;

    always_comb begin
        head_d  = drain   ? head_q + PW'(1) : head_q;
        tail_d  = do_push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        ovf_d   = ovf_q | (push & ~room);
        unique case ({do_push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[tail_q] <= '{adr:  bus.evicted_adr,
                               data: bus.evicted_data};
        else if (coal)
            mem_q[cidx].data <= bus.evicted_data;
    end

    assign bus.full     = count_q == CW'(DEPTH);
    assign bus.overflow = ovf_q;
    assign bus.wr_valid = count_q != '0;
    assign bus.wr_adr   = mem_q[head_q].adr;
    assign bus.wr_data  = mem_q[head_q].data;

`ifdef VICTIM_FWD_EN
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;

    // Head draining this cycle is still in qmask, so it hits.
    always_comb begin
        hit_d   = 1'b0;
        ldata_d = '0;
        if (bus.lookup_en)
            for (int i = 0; i < DEPTH; i++)
                if (!hit_d && qmask[i] &&
                    mem_q[i].adr == bus.lookup_adr) begin
                    hit_d   = 1'b1;
                    ldata_d = mem_q[i].data;
                end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            ldata_q <= '0;
        end else begin
            hit_q   <= hit_d;
            ldata_q <= ldata_d;
        end
    end

    assign bus.lookup_hit  = hit_q;
    assign bus.lookup_data = ldata_q;
`else
    logic unused_lookup;
    assign unused_lookup   = ^{bus.lookup_adr, bus.lookup_en};
    assign bus.lookup_hit  = 1'b0;
    assign bus.lookup_data = '0;
`endif

    if (DEBUG != 0) begin : g_trace
        always @(posedge clk) begin
            if (!rst) begin
                if (do_push)
                    $display("vwb push %h %h",
                             bus.evicted_adr, bus.evicted_data);
                if (coal)
                    $display("vwb coalesce %h %h",
                             bus.evicted_adr, bus.evicted_data);
                if (drain)
                    $display("vwb drain %h %h",
                             bus.wr_adr, bus.wr_data);
                if (bus.lookup_hit)
                    $display("vwb hit %h", bus.lookup_data);
            end
        end
    end

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Scoreboard bench for victim_wb_buffer (DEPTH=4).
module tb_victim_wb_buffer;
    import victim_pkg::*;

`ifdef VICTIM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    victim_entry_t exp_q[$];

    victim_wb_buffer_if bus ();

    victim_wb_buffer #(.DEPTH(4), .DEBUG(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Drains sampled between edges, compared against expected order.
    always begin
        victim_entry_t e;
        @(negedge clk);
        #2;
        if (!rst && bus.wr_valid && bus.wr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_extra got %h/%h want none",
                         bus.wr_adr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_adr !== e.adr ||
                    bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL drain got %h/%h want %h/%h",
                             bus.wr_adr, bus.wr_data,
                             e.adr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a,
                        input logic [15:0] d);
        bus.evicted_adr   = a;
        bus.evicted_data  = d;
        bus.evicted_valid = 1'b1;
        tick();
        bus.evicted_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0 || bus.full !== 1'b0 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v%b f%b o%b want 000",
                     bus.wr_valid, bus.full, bus.overflow);
        end
        checks++;
        if (bus.lookup_hit !== 1'b0 ||
            bus.lookup_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_lookup got %b/%h want 0/0000",
                     bus.lookup_hit, bus.lookup_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.wr_ready = 1'b1;
        exp_q.push_back('{adr: 16'h0010, data: 16'h1111});
        push(16'h0010, 16'h1111);
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_adr !== 16'h0010 ||
            bus.wr_data !== 16'h1111) begin
            errors++;
            $display("FAIL single got %b %h/%h want 1 0010/1111",
                     bus.wr_valid, bus.wr_adr, bus.wr_data);
        end
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty got %b want 0",
                     bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_coalesce();
        bus.wr_ready = 1'b0;
        exp_q.push_back('{adr: 16'h0010, data: 16'h2222});
        push(16'h0010, 16'h1111);
        push(16'h0010, 16'h2222);
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h2222) begin
            errors++;
            $display("FAIL coalesce got %b/%h want 1/2222",
                     bus.wr_valid, bus.wr_data);
        end
        bus.wr_ready = 1'b1;
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_count got %b want 0",
                     bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{adr: 16'h0100 + 16'(i),
                              data: 16'hA000 + 16'(i)});
            push(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        end
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full4 got f%b o%b want f1 o0",
                     bus.full, bus.overflow);
        end
        push(16'h0104, 16'hA004);
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow got f%b o%b want f1 o1",
                     bus.full, bus.overflow);
        end
        bus.wr_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus.wr_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain got v%b o%b want v0 o1",
                     bus.wr_valid, bus.overflow);
        end
        bus.wr_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_drain();
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{adr: 16'h0200 + 16'(i),
                              data: 16'hB000 + 16'(i)});
            push(16'h0200 + 16'(i), 16'hB000 + 16'(i));
        end
        exp_q.push_back('{adr: 16'h0050, data: 16'h5050});
        bus.wr_ready = 1'b1;
        push(16'h0050, 16'h5050);
        bus.wr_ready = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got f%b o%b want f1 o0",
                     bus.full, bus.overflow);
        end
        bus.wr_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_empty got %b want 0",
                     bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.wr_ready = 1'b0;
        exp_q.push_back('{adr: 16'h0040, data: 16'h0001});
        exp_q.push_back('{adr: 16'h0040, data: 16'h0002});
        push(16'h0040, 16'h0001);
        bus.wr_ready = 1'b1;
        push(16'h0040, 16'h0002);
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_adr !== 16'h0040 ||
            bus.wr_data !== 16'h0002) begin
            errors++;
            $display("FAIL b2b got %b %h/%h want 1 0040/0002",
                     bus.wr_valid, bus.wr_adr, bus.wr_data);
        end
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got %b want 0", bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_lookup();
        logic        eh;
        logic [15:0] ed;
        bus.wr_ready = 1'b0;
        exp_q.push_back('{adr: 16'h0020, data: 16'hBEEF});
        exp_q.push_back('{adr: 16'h0021, data: 16'hCAFE});
        push(16'h0020, 16'hBEEF);
        push(16'h0021, 16'hCAFE);
        bus.lookup_en  = 1'b1;
        bus.lookup_adr = 16'h0020;
        tick();
        eh = FWD;
        ed = FWD ? 16'hBEEF : 16'h0;
        checks++;
        if (bus.lookup_hit !== eh || bus.lookup_data !== ed) begin
            errors++;
            $display("FAIL lookup_head got %b/%h want %b/%h",
                     bus.lookup_hit, bus.lookup_data, eh, ed);
        end
        bus.lookup_adr = 16'h0021;
        tick();
        ed = FWD ? 16'hCAFE : 16'h0;
        checks++;
        if (bus.lookup_hit !== eh || bus.lookup_data !== ed) begin
            errors++;
            $display("FAIL lookup_tail got %b/%h want %b/%h",
                     bus.lookup_hit, bus.lookup_data, eh, ed);
        end
        bus.lookup_adr = 16'h0030;
        tick();
        checks++;
        if (bus.lookup_hit !== 1'b0 ||
            bus.lookup_data !== 16'h0) begin
            errors++;
            $display("FAIL lookup_miss got %b/%h want 0/0000",
                     bus.lookup_hit, bus.lookup_data);
        end
        bus.lookup_en  = 1'b0;
        bus.lookup_adr = 16'h0020;
        tick();
        checks++;
        if (bus.lookup_hit !== 1'b0) begin
            errors++;
            $display("FAIL lookup_idle got %b want 0",
                     bus.lookup_hit);
        end
        bus.lookup_en = 1'b1;
        bus.wr_ready  = 1'b1;
        tick();
        bus.lookup_en = 1'b0;
        ed = FWD ? 16'hBEEF : 16'h0;
        checks++;
        if (bus.lookup_hit !== eh || bus.lookup_data !== ed) begin
            errors++;
            $display("FAIL lookup_drain got %b/%h want %b/%h",
                     bus.lookup_hit, bus.lookup_data, eh, ed);
        end
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL lookup_empty got %b want 0",
                     bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(16'h0060 + 16'(i), 16'h6000 + 16'(i));
        exp_q.push_back('{adr: 16'h0060, data: 16'h6000});
        bus.lookup_en  = 1'b1;
        bus.lookup_adr = 16'h0061;
        bus.wr_ready   = 1'b1;
        tick();
        bus.lookup_en = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.wr_valid !== 1'b1 ||
            bus.lookup_hit !== FWD) begin
            errors++;
            $display("FAIL pre_rst got o%b v%b h%b want 1 1 %b",
                     bus.overflow, bus.wr_valid,
                     bus.lookup_hit, FWD);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_valid !== 1'b0 || bus.full !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.lookup_hit !== 1'b0 ||
            bus.lookup_data !== 16'h0) begin
            errors++;
            $display("FAIL async_rst got v%b f%b o%b h%b want 0000",
                     bus.wr_valid, bus.full, bus.overflow,
                     bus.lookup_hit);
        end
        bus.wr_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back('{adr: 16'h0070, data: 16'h7777});
        push(16'h0070, 16'h7777);
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_adr !== 16'h0070) begin
            errors++;
            $display("FAIL post_rst got %b/%h want 1/0070",
                     bus.wr_valid, bus.wr_adr);
        end
        bus.wr_ready = 1'b1;
        tick();
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_sole got %b want 0",
                     bus.wr_valid);
        end
        bus.wr_ready = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        bus.evicted_adr   = '0;
        bus.evicted_data  = '0;
        bus.evicted_valid = 1'b0;
        bus.wr_ready      = 1'b0;
        bus.lookup_adr    = '0;
        bus.lookup_en     = 1'b0;
        test_reset();
        test_single();
        test_coalesce();
        test_overflow();
        test_full_drain();
        test_back_to_back();
        test_lookup();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
